ieeedrv_sd_arb: RTL
===================

# ieeedrv_sd_arb

Shares the single MiSTer SD block interface (`sd_lba`/`sd_blk_cnt`/`sd_rd`/`sd_wr`/`sd_ack` plus sector-buffer byte port) between several IEEE drive track controllers. Each requester issues whole-track read or write requests. The arbiter grants one requester at a time in round-robin order and forwards the request to the host. It routes `sd_ack` and the sector-buffer strobes/data to the granted requester only. It sits between the per-unit track sequencers and the top-level HPS SD port.

## Interface
- `NREQ`, default 2: number of requesters (1..8).
- `TIMEOUT`, default 24'd16_000_000: `clk_sys` cycles allowed from host request to `sd_ack` rise before abort. A value of 0 disables the timeout.
- `clk_sys` input, 1 bit: system clock. Single clock domain.
- `reset` input, 1 bit: synchronous, active-high.
- `req_lba[NREQ]` input, 32 bits each: start LBA per requester.
- `req_blk_cnt[NREQ]` input, 6 bits each: block count minus one.
- `req_rd` input, NREQ bits: read request, level, held until own ack.
- `req_wr` input, NREQ bits: write request, same rules as `req_rd`.
- `req_ack` output, NREQ bits: `sd_ack` routed to the granted requester, 0 for all others.
- `req_buff_wr` output, NREQ bits: `sd_buff_wr` routed to the granted requester.
- `req_buff_dout[NREQ]` input, 8 bits each: requester buffer read data, used on writes.
- `req_err` output, NREQ bits: one-cycle timeout-abort pulse.
- `sd_lba` output, 32 bits; `sd_blk_cnt` output, 6 bits; `sd_rd` output, 1 bit; `sd_wr` output, 1 bit: host request.
- `sd_ack` input, 1 bit: host acknowledge, high for the whole transfer.
- `sd_buff_wr` input, 1 bit: host byte strobe into the buffer.
- `sd_buff_din` output, 8 bits: `req_buff_dout` of the granted requester, 0 when idle.
- `grant` output, 3 bits: index of the granted requester. Valid when `busy` is high.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- States:
  - IDLE
  - ISSUE: host request asserted, waiting for `sd_ack` rise.
  - XFER: `sd_ack` high.
  - FLUSH: waiting for `sd_ack` low after reset or abort.
- IDLE:
  - Scan `req_rd|req_wr` starting at `rr_ptr` and wrapping modulo NREQ. The first set index is granted.
  - Latch `grant`, `sd_lba`, `sd_blk_cnt`.
  - Set `sd_wr` if that requester's `req_wr` is set, otherwise set `sd_rd`. Write wins when both are set.
  - Go to ISSUE.
- ISSUE:
  - On `sd_ack` high: clear `sd_rd`/`sd_wr`, go to XFER.
  - Requester withdrawal is ignored once a request is issued.
  - Timeout counter reaches TIMEOUT: clear `sd_rd`/`sd_wr`, pulse `req_err[grant]`, set `rr_ptr`=grant+1, go to IDLE.
- XFER:
  - On `sd_ack` low: set `rr_ptr` = (grant+1) mod NREQ, go to IDLE.
- FLUSH:
  - Stay until `sd_ack` is low, then go to IDLE.
- Routing is combinational:
  - `req_ack[i]` = `sd_ack` & busy & (grant==i) & state∈{ISSUE,XFER}.
  - `req_buff_wr[i]` = `sd_buff_wr` & state==XFER & grant==i.
- The timeout counter is 24 bits, cleared on entry to ISSUE, and saturates.

## Timing
- Reset values:
  - State FLUSH.
  - `sd_rd`=`sd_wr`=0; `sd_lba`=0; `sd_blk_cnt`=0.
  - `grant`=0; `rr_ptr`=0; `busy`=1 until FLUSH exits; `req_err`=0.
- Reset mid-transfer:
  - Outputs are cleared the same cycle.
  - Stale `sd_ack`/`sd_buff_wr` are never routed.
- Request seen in IDLE at cycle N: `sd_rd`/`sd_wr` high at N+1.
- `sd_ack` rise at cycle M: `sd_rd`/`sd_wr` low at M+1; `req_ack` high combinationally at M.
- `sd_ack` fall at cycle K: IDLE at K+1. The next grant can be issued at K+2.
- `sd_ack` rise and a new request in the same cycle have no interaction; only the granted path advances.
- Requester re-raising immediately after its own ack is served only after the other pending requesters (round-robin).

## Structure
- Shared package `ieeedrv_pkg`:
  - State enum `sd_arb_state_t`.
  - `SD_BLK_CNT_W`=6.
  - Default TIMEOUT constant.
- Sub-module `ieeedrv_rr_pick`: combinational round-robin priority pick. Inputs are the request vector and `rr_ptr`; outputs are valid and index.
- All other logic stays in `ieeedrv_sd_arb`.

## Test plan
- Single request: `req_rd[0]`, LBA 0x1D, cnt 28 → `sd_rd`=1, `sd_lba`=0x1D, `sd_blk_cnt`=28 one cycle later. Ack 200 cycles → `req_ack[0]` tracks it and `req_ack[1]`=0.
- Simultaneous `req_rd[0]`, `req_wr[1]` from reset → grant 0 first, then grant 1 with `sd_wr`=1. With both held continuously, grants alternate 0,1,0,1.
- `req_rd[1]`=`req_wr[1]`=1 → `sd_wr`=1, `sd_rd`=0.
- Buffer routing: grant 1 in XFER, 512 `sd_buff_wr` pulses → exactly 512 on `req_buff_wr[1]`, none on index 0. `sd_buff_din` equals `req_buff_dout[1]`.
- TIMEOUT=100, no ack → `sd_rd` drops and `req_err[grant]` pulses at cycle 101 after issue. Next pending requester is granted.
- Reset asserted mid-XFER with `sd_ack` still high → `sd_rd`/`sd_wr`=0 and no `req_ack`/`req_buff_wr` until `sd_ack` falls. A new request is then served normally.

Source files
------------

// File: rtl/ieeedrv_pkg.sv
// ieeedrv_pkg: shared state enum, SD block-count width and default host timeout for the IEEE drive SD arbiter
package ieeedrv_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_XFER, ST_FLUSH} sd_arb_state_t;
  localparam int SD_BLK_CNT_W = 6;
  localparam logic [23:0] SD_TIMEOUT_DEF = 24'd16_000_000;
endpackage

// File: rtl/ieeedrv_sd_arb_if.sv
// ieeedrv_sd_arb_if: MiSTer SD block port (lba/blk_cnt/rd/wr out, ack/buff_wr in, buff_din out); master=arbiter, slave=host
interface ieeedrv_sd_arb_if;
  import ieeedrv_pkg::*;
  logic [31:0] sd_lba;
  logic [SD_BLK_CNT_W-1:0] sd_blk_cnt;
  logic sd_rd;
  logic sd_wr;
  logic sd_ack;
  logic sd_buff_wr;
  logic [7:0] sd_buff_din;
  modport master(output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din, input sd_ack, sd_buff_wr);
  modport slave(input sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din, output sd_ack, sd_buff_wr);
endinterface

// File: rtl/ieeedrv_rr_pick.sv
// ieeedrv_rr_pick: combinational round-robin pick (req, ptr -> valid, idx of first set request at or after ptr)
module ieeedrv_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            valid,
  output logic [2:0]      idx
);
  logic [NREQ-1:0] rot;
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    valid = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        valid = 1'b1;
        idx = 3'((int'(ptr) + k) % NREQ);
      end
  end
endmodule

// File: rtl/ieeedrv_sd_arb.sv
// ieeedrv_sd_arb: round-robin share of one SD block port (sd) among NREQ track requesters (req_*), with grant/busy status
module ieeedrv_sd_arb
  import ieeedrv_pkg::*;
#(
  parameter int          NREQ    = 2,
  parameter logic [23:0] TIMEOUT = SD_TIMEOUT_DEF
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [31:0]             req_lba [NREQ],
  input  logic [SD_BLK_CNT_W-1:0] req_blk_cnt [NREQ],
  input  logic [NREQ-1:0]         req_rd,
  input  logic [NREQ-1:0]         req_wr,
  output logic [NREQ-1:0]         req_ack,
  output logic [NREQ-1:0]         req_buff_wr,
  input  logic [7:0]              req_buff_dout [NREQ],
  output logic [NREQ-1:0]         req_err,
  output logic [2:0]              grant,
  output logic                    busy,
  ieeedrv_sd_arb_if.master        sd
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  sd_arb_state_t state, state_d;
  logic [2:0] grant_d, rr_ptr, rr_d, pick_idx, grant_nx;
  logic pick_valid, rd_q, rd_d, wr_q, wr_d, routed;
  logic [31:0] lba_q, lba_d;
  logic [SD_BLK_CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] err_d;
  logic [23:0] tmr, tmr_d;
  ieeedrv_rr_pick #(.NREQ(NREQ)) u_pick (
    .req(req_rd | req_wr),
    .ptr(rr_ptr),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  assign grant_nx = grant == 3'(NREQ - 1) ? 3'd0 : grant + 3'd1;
  always_comb begin
    state_d = state;
    grant_d = grant;
    rr_d = rr_ptr;
    lba_d = lba_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    wr_d = wr_q;
    err_d = '0;
    tmr_d = &tmr ? tmr : tmr + 24'd1;
    case (state)
      ST_IDLE:
        if (pick_valid) begin
          state_d = ST_ISSUE;
          grant_d = pick_idx;
          lba_d = req_lba[pick_idx[IW-1:0]];
          cnt_d = req_blk_cnt[pick_idx[IW-1:0]];
          wr_d = req_wr[pick_idx[IW-1:0]];
          rd_d = !req_wr[pick_idx[IW-1:0]];
          tmr_d = '0;
        end
      ST_ISSUE:
        if (sd.sd_ack) begin
          state_d = ST_XFER;
          rd_d = 1'b0;
          wr_d = 1'b0;
        end else if (TIMEOUT != 24'd0 && tmr >= TIMEOUT) begin
          state_d = ST_IDLE;
          rd_d = 1'b0;
          wr_d = 1'b0;
          err_d[grant[IW-1:0]] = 1'b1;
          rr_d = grant_nx;
        end
      ST_XFER:
        if (!sd.sd_ack) begin
          state_d = ST_IDLE;
          rr_d = grant_nx;
        end
      default: state_d = sd.sd_ack ? ST_FLUSH : ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= ST_FLUSH;
      grant <= '0;
      rr_ptr <= '0;
      lba_q <= '0;
      cnt_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      req_err <= '0;
      tmr <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      rr_ptr <= rr_d;
      lba_q <= lba_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      req_err <= err_d;
      tmr <= tmr_d;
    end
  end
  assign busy = state != ST_IDLE;
  assign routed = !reset && (state == ST_ISSUE || state == ST_XFER);
  for (genvar i = 0; i < NREQ; i++) begin : g_route
    assign req_ack[i] = sd.sd_ack && routed && grant == 3'(i);
    assign req_buff_wr[i] = sd.sd_buff_wr && routed && state == ST_XFER && grant == 3'(i);
  end
  assign sd.sd_lba = lba_q;
  assign sd.sd_blk_cnt = cnt_q;
  assign sd.sd_rd = rd_q;
  assign sd.sd_wr = wr_q;
  assign sd.sd_buff_din = busy ? req_buff_dout[grant[IW-1:0]] : 8'd0;
endmodule
